or_n: RTL and testbench



---
 rtl/or_n_pkg.sv | 15 +
 rtl/or_n_if.sv | 40 ++++
 rtl/or_n_core.sv | 22 ++
 rtl/or_n.sv | 102 ++++++++++
 tb/tb_or_n.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/or_n_pkg.sv
// ---------------------------------------------------------------------------
// or_n_pkg
// Shared constants and types for the N-bit OR unit and its ALU-side users.
//   OR_N_DEFAULT_W : default operand/result width
//   OR_N_MAX_W     : widest legal operand/result width
//   or_n_word_t    : default-width ALU word
// ---------------------------------------------------------------------------
package or_n_pkg;

  localparam int OR_N_DEFAULT_W = 8;
  localparam int OR_N_MAX_W     = 64;

  typedef logic [OR_N_DEFAULT_W-1:0] or_n_word_t;

endpackage

// File: rtl/or_n_if.sv
// ---------------------------------------------------------------------------
// or_n_if
// Signal bundle for the OR unit: operands, capture qualifier, combinational
// result and the registered result view.
// Modports:
//   master : drives a, b, in_valid; observes every result signal
//   slave  : the unit side; receives a, b, in_valid; drives the results
//   core   : the combinational slice; receives a, b; drives f
// ---------------------------------------------------------------------------
interface or_n_if
  import or_n_pkg::*;
#(
  parameter int N = OR_N_DEFAULT_W
) ();

  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         in_valid;
  logic [N-1:0] f;
  logic [N-1:0] f_q;
  logic         out_valid;
  logic         zero_q;
  logic         ones_q;

  modport master (
    output a, b, in_valid,
    input  f, f_q, out_valid, zero_q, ones_q
  );

  modport slave (
    input  a, b, in_valid,
    output f, f_q, out_valid, zero_q, ones_q
  );

  modport core (
    input  a, b,
    output f
  );

endinterface

// File: rtl/or_n_core.sv
// ---------------------------------------------------------------------------
// or_n_core
// Pure combinational per-bit OR: bus.f[i] = bus.a[i] | bus.b[i].
// Ports:
//   bus (or_n_if.core) : a, b in; f out. Width N must match the bus.
// ---------------------------------------------------------------------------
module or_n_core
  import or_n_pkg::*;
#(
  parameter int N = OR_N_DEFAULT_W
) (
  or_n_if.core bus
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign bus.f[gi] = bus.a[gi] | bus.b[gi];
    end
  endgenerate

endmodule

// File: rtl/or_n.sv
// ---------------------------------------------------------------------------
// or_n
// N-bit bitwise OR for the single-cycle ALU. f is combinational; f_q is a
// one-cycle registered copy qualified by in_valid, with out_valid and
// optional zero/ones result flags.
// Optional feature macro: OR_N_FLAGS_EN (builds zero_q/ones_q registers;
// otherwise both are tied to 0, port list unchanged).
// Ports:
//   f         out N  a | b, combinational
//   a, b      in  N  operands
//   clk       in  1  clock, rising edge
//   reset     in  1  asynchronous, active-high; does not affect f
//   in_valid  in  1  qualifies a/b for capture
//   f_q       out N  registered result (holds when in_valid = 0)
//   out_valid out 1  f_q was captured on the previous edge
//   zero_q    out 1  captured result was all zeros (flags build only)
//   ones_q    out 1  captured result was all ones  (flags build only)
// ---------------------------------------------------------------------------
module or_n
  import or_n_pkg::*;
#(
  parameter int N = OR_N_DEFAULT_W
) (
  output logic [N-1:0] f,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic [N-1:0] f_q,
  output logic         out_valid,
  output logic         zero_q,
  output logic         ones_q
);

  generate
    if (N < 1 || N > OR_N_MAX_W) begin : g_bad_width
      $error("or_n: N=%0d outside legal range 1..%0d", N, OR_N_MAX_W);
    end
  endgenerate

  // Internal bundle: the core sees operands through its modport, and the
  // registered view is published on the same bundle before reaching ports.
  or_n_if #(.N(N)) w_bus ();

  logic [N-1:0] w_f;
  logic [N-1:0] r_f_q;
  logic         r_out_valid;

  assign w_bus.a        = a;
  assign w_bus.b        = b;
  assign w_bus.in_valid = in_valid;

  or_n_core #(.N(N)) u_core (
    .bus (w_bus.core)
  );

  assign w_f = w_bus.f;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f_q       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_bus.in_valid;
      if (w_bus.in_valid) begin
        r_f_q <= w_f;
      end
    end
  end

`ifdef OR_N_FLAGS_EN
  logic r_zero_q;
  logic r_ones_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_zero_q <= 1'b0;
      r_ones_q <= 1'b0;
    end else if (w_bus.in_valid) begin
      r_zero_q <= ~|w_f;
      r_ones_q <= &w_f;
    end
  end

  assign w_bus.zero_q = r_zero_q;
  assign w_bus.ones_q = r_ones_q;
`else
  assign w_bus.zero_q = 1'b0;
  assign w_bus.ones_q = 1'b0;
`endif

  assign w_bus.f_q       = r_f_q;
  assign w_bus.out_valid = r_out_valid;

  assign f         = w_bus.f;
  assign f_q       = w_bus.f_q;
  assign out_valid = w_bus.out_valid;
  assign zero_q    = w_bus.zero_q;
  assign ones_q    = w_bus.ones_q;

endmodule

// File: tb/tb_or_n.sv
// ---------------------------------------------------------------------------
// tb_or_n
// Directed and random checks of or_n at N = 8, flags build or default build.
// ---------------------------------------------------------------------------
module tb_or_n;
  import or_n_pkg::*;

  localparam int N = 8;

`ifdef OR_N_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  or_n_if #(.N(N)) bus ();

  or_n #(.N(N)) dut (
    .f         (bus.f),
    .a         (bus.a),
    .b         (bus.b),
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bus.in_valid),
    .f_q       (bus.f_q),
    .out_valid (bus.out_valid),
    .zero_q    (bus.zero_q),
    .ones_q    (bus.ones_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive a vector at the falling edge, check f shortly after, then check the
  // registered outputs 1 time unit after the following rising edge.
  task automatic vec(input or_n_word_t va, input or_n_word_t vb, input logic v,
                     input or_n_word_t exp_f, input or_n_word_t exp_fq,
                     input logic exp_ov, input logic exp_z, input logic exp_o);
    @(negedge clk);
    bus.a = va; bus.b = vb; bus.in_valid = v;
    #2;
    check("f", bus.f, exp_f);
    @(posedge clk);
    #1;
    check("f_q", bus.f_q, exp_fq);
    check("out_valid", bus.out_valid, exp_ov);
    check("zero_q", bus.zero_q, exp_z & FLAGS);
    check("ones_q", bus.ones_q, exp_o & FLAGS);
  endtask

  or_n_word_t ra, rb, m_fq;
  logic       rv, m_ov, m_z, m_o;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.a = '0; bus.b = '0; bus.in_valid = 1'b0;
    #2;
    check("rst_f_q", bus.f_q, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_zero_q", bus.zero_q, 0);
    check("rst_ones_q", bus.ones_q, 0);
    check("rst_f", bus.f, 0);
    // Reset held across an edge with in_valid high: nothing is captured.
    bus.a = 8'h3C; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    check("rst_hold_f_q", bus.f_q, 0);
    check("rst_hold_ov", bus.out_valid, 0);
    check("rst_f_live", bus.f, 8'h3C);
    @(negedge clk);
    reset = 1'b0; bus.in_valid = 1'b0; bus.a = '0;

    //   a      b      v     f      f_q    ov    z     o
    vec(8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    vec(8'h0F, 8'h5A, 1'b1, 8'h5F, 8'h5F, 1'b1, 1'b0, 1'b0);
    vec(8'hFF, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
    vec(8'h01, 8'h01, 1'b1, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0);
    vec(8'hAA, 8'h55, 1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    vec(8'h80, 8'h00, 1'b1, 8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
    vec(8'h00, 8'hFF, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
    // Flags hold with f_q while in_valid is low.
    vec(8'h00, 8'h00, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
    vec(8'h0F, 8'h5A, 1'b1, 8'h5F, 8'h5F, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges.
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_f_q", bus.f_q, 0);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_zero_q", bus.zero_q, 0);
    check("arst_ones_q", bus.ones_q, 0);
    bus.a = 8'h12; bus.b = 8'h40;
    #1;
    check("arst_f_live", bus.f, 8'h52);
    @(negedge clk);
    reset = 1'b0;
    vec(8'h12, 8'h40, 1'b0, 8'h52, 8'h00, 1'b0, 1'b0, 1'b0);
    vec(8'h12, 8'h40, 1'b1, 8'h52, 8'h52, 1'b1, 1'b0, 1'b0);

    // Random phase with a reference model.
    m_fq = 8'h52; m_ov = 1'b1; m_z = 1'b0; m_o = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ra = or_n_word_t'($urandom_range(0, 255));
      rb = or_n_word_t'($urandom_range(0, 255));
      if (i % 97 == 0) rb = ~ra;
      if (i % 89 == 0) begin ra = '0; rb = '0; end
      rv = 1'($urandom_range(0, 1));
      bus.a = ra; bus.b = rb; bus.in_valid = rv;
      #1;
      check("rnd_f", bus.f, ra | rb);
      check("rnd_f_known", 64'($isunknown(bus.f)), 0);
      @(posedge clk);
      #1;
      m_ov = rv;
      if (rv) begin
        m_fq = ra | rb;
        m_z  = ((ra | rb) == '0);
        m_o  = ((ra | rb) == '1);
      end
      check("rnd_f_q", bus.f_q, m_fq);
      check("rnd_out_valid", bus.out_valid, m_ov);
      check("rnd_zero_q", bus.zero_q, m_z & FLAGS);
      check("rnd_ones_q", bus.ones_q, m_o & FLAGS);
      check("rnd_known", 64'($isunknown({bus.f_q, bus.out_valid, bus.zero_q, bus.ones_q})), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
